// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller slice.
// Optional build macro used by the controller: SAR_CTRL_COMP_SETTLE_EN.
package sar_adc_pkg;

  localparam int SAR_N_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } sar_state_e;

  typedef logic [SAR_N_BITS-1:0] sar_code_t;

endpackage

// File: rtl/sar_trial_register.sv
// Trial code register for the binary search. It holds the code driven to the
// DAC plus a one-hot pointer marking the bit currently under trial.
// A step resolves the pointed bit from comp_in and then arms the next lower bit.
module sar_trial_register
  import sar_adc_pkg::*;
#(
  parameter int N_BITS = SAR_N_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_msb,
  input  logic              step,
  input  logic              comp_in,
  output logic [N_BITS-1:0] code,
  output logic              last_bit
);

  localparam logic [N_BITS-1:0] MSB_ONLY = {1'b1, {(N_BITS-1){1'b0}}};

  logic [N_BITS-1:0] code_q, code_d;
  logic [N_BITS-1:0] ptr_q, ptr_d;
  logic [N_BITS-1:0] ptr_shift;
  logic [N_BITS-1:0] code_step;

  // After the last bit the pointer shifts out to zero, so no new bit is armed.
  assign ptr_shift = ptr_q >> 1;

  // Per bit: drop the pointed bit when the comparator says Vin < Vdac,
  // then set the bit that becomes the next trial.
  for (genvar gi = 0; gi < N_BITS; gi++) begin : g_bit
    assign code_step[gi] = (code_q[gi] & ~(ptr_q[gi] & ~comp_in)) | ptr_shift[gi];
  end

  // Next-state selection: clear wins over load, load wins over step.
  always_comb begin
    code_d = code_q;
    ptr_d  = ptr_q;
    if (clear) begin
      code_d = '0;
      ptr_d  = '0;
    end else if (load_msb) begin
      code_d = MSB_ONLY;
      ptr_d  = MSB_ONLY;
    end else if (step) begin
      code_d = code_step;
      ptr_d  = ptr_shift;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      ptr_q  <= '0;
    end else begin
      code_q <= code_d;
      ptr_q  <= ptr_d;
    end
  end

  assign code     = code_q;
  assign last_bit = ptr_q[0];

endmodule

// File: rtl/sar_successive_approx_controller.sv
// SAR ADC successive-approximation controller: sample, binary search MSB
// first against the comparator, publish the final code with a done pulse.
// Build macro SAR_CTRL_COMP_SETTLE_EN: each bit trial takes a SETTLE cycle
// followed by a DECIDE cycle, and comp_in is only used on the DECIDE edge.
module sar_successive_approx_controller
  import sar_adc_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              comp_in,
  output logic              track,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  sar_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              track_q;
  logic              busy_q;
  logic              done_q;
  logic [N_BITS-1:0] result_q;

  logic              last_sample;
  logic              decide;
  logic              trial_clear;
  logic              trial_load;
  logic              trial_step;
  logic [N_BITS-1:0] trial_code;
  logic              trial_last;

`ifdef SAR_CTRL_COMP_SETTLE_EN
  logic settle_q;
  // settle_q low = SETTLE cycle, high = DECIDE cycle.
  assign decide = settle_q;
`else
  assign decide = 1'b1;
`endif

  assign last_sample = (state_q == SAMPLE) && (cnt_q == CNT_LAST);
  assign trial_clear = (state_q == DONE);
  assign trial_load  = last_sample;
  assign trial_step  = (state_q == CONVERT) && decide;

  sar_trial_register #(
    .N_BITS (N_BITS)
  ) u_trial (
    .clk      (clk),
    .reset    (reset),
    .clear    (trial_clear),
    .load_msb (trial_load),
    .step     (trial_step),
    .comp_in  (comp_in),
    .code     (trial_code),
    .last_bit (trial_last)
  );

  // Conversion FSM with registered status outputs and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      track_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef SAR_CTRL_COMP_SETTLE_EN
      settle_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
            track_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SAMPLE: begin
          if (last_sample) begin
            state_q <= CONVERT;
            track_q <= 1'b0;
`ifdef SAR_CTRL_COMP_SETTLE_EN
            settle_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
`ifdef SAR_CTRL_COMP_SETTLE_EN
          settle_q <= ~settle_q;
`endif
          if (trial_step && trial_last) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            // The LSB is the bit resolved on this edge; upper bits are final.
            result_q <= {trial_code[N_BITS-1:1], comp_in};
          end
        end
        DONE: begin
          if (start) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
            track_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign track    = track_q;
  assign dac_code = trial_code;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_sar_successive_approx_controller.sv
// Self-checking bench for sar_successive_approx_controller with an ideal
// combinational comparator (comp_in = vin_code >= dac_code) and stuck modes.
module tb_sar_successive_approx_controller;

  localparam int N  = 11;
  localparam int SC = 2;
`ifdef SAR_CTRL_COMP_SETTLE_EN
  localparam int BIT_CYC = 2;
`else
  localparam int BIT_CYC = 1;
`endif
  localparam int LAT     = SC + BIT_CYC * N + 1;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         comp_in;
  logic         track;
  logic         busy;
  logic         done;
  logic [N-1:0] dac_code;
  logic [N-1:0] result;

  logic [N-1:0] vin_code = '0;
  int           comp_mode = 0;       // 0 ideal, 1 stuck high, 2 stuck low
  logic         comp_invert = 1'b0;  // corrupts the comparator output

  int n_checks = 0;
  int n_fail = 0;

  logic [N-1:0] dac_trace[$];
  logic         track_trace[$];
  logic         busy_trace[$];

  sar_successive_approx_controller dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .comp_in  (comp_in),
    .track    (track),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (comp_mode)
      1:       comp_in = 1'b1;
      2:       comp_in = 1'b0;
      default: comp_in = (vin_code >= dac_code);
    endcase
    if (comp_invert) comp_in = ~comp_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Trial i of a binary search for vin: the bits above position N-1-i are
  // already resolved (equal vin's), the bit under test is set, lower bits 0.
  function automatic logic [N-1:0] model_trial(input logic [N-1:0] vin, input int i);
    int unsigned p;
    int unsigned v;
    p = 1 << (N - 1 - i);
    v = vin;
    return N'((v / (2 * p)) * (2 * p) + p);
  endfunction

  function automatic logic [N-1:0] model_result(input logic [N-1:0] vin, input int mode);
    if (mode == 1) return N'((1 << N) - 1);
    if (mode == 2) return '0;
    return vin;
  endfunction

  function automatic logic [N-1:0] trace_at(input int idx);
    if (idx < dac_trace.size()) return dac_trace[idx];
    return 'x;
  endfunction

  // Starts one conversion from IDLE and records outputs each cycle until done.
  // lat = index of the cycle where done is seen (accept edge = 1), -1 on timeout.
  task automatic run_conversion(input logic [N-1:0] vin, input bit corrupt, output int lat);
    vin_code = vin;
    dac_trace.delete();
    track_trace.delete();
    busy_trace.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      comp_invert = corrupt && (c >= SC + 1) && (c <= SC + 2 * N) && (((c - SC - 1) % 2) == 0);
      dac_trace.push_back(dac_code);
      track_trace.push_back(track);
      busy_trace.push_back(busy);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    comp_invert = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (track !== 1'b0) begin n_fail++; $display("FAIL reset_track: got %b expected 0", track); end
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL reset_dac: got %h expected 000", dac_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 000", result); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    logic [N-1:0] exp_t;
    run_conversion(N'(1234), 1'b0, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (result !== N'(1234)) begin n_fail++; $display("FAIL basic_result: got %h expected %h", result, N'(1234)); end
    for (int s = 0; s < SC; s++) begin
      n_checks++;
      if ((s >= track_trace.size()) || track_trace[s] !== 1'b1 || trace_at(s) !== '0) begin
        n_fail++; $display("FAIL basic_sample%0d: dac %h expected 000 with track high", s, trace_at(s));
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_t = model_trial(N'(1234), i);
      n_checks++;
      if (trace_at(SC + i * BIT_CYC) !== exp_t) begin
        n_fail++; $display("FAIL basic_trial%0d: got %h expected %h", i, trace_at(SC + i * BIT_CYC), exp_t);
      end
    end
    n_checks++; if (dac_code !== N'(1234)) begin n_fail++; $display("FAIL basic_done_dac: got %h expected %h", dac_code, N'(1234)); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL basic_dac_idle: got %h expected 000", dac_code); end
    n_checks++; if (result !== N'(1234)) begin n_fail++; $display("FAIL basic_result_hold: got %h expected %h", result, N'(1234)); end
    $display("test_basic vin=%h result=%h latency=%0d", N'(1234), result, lat);
  endtask

  task automatic test_values();
    logic [N-1:0] vins[10];
    int           modes[10];
    int           lat;
    logic [N-1:0] exp_r;
    vins[0] = N'(2047); modes[0] = 0;
    vins[1] = N'(0);    modes[1] = 0;
    vins[2] = N'(1024); modes[2] = 0;
    vins[3] = N'(1023); modes[3] = 0;
    vins[4] = N'($urandom_range(2047, 0)); modes[4] = 1;
    vins[5] = N'($urandom_range(2047, 0)); modes[5] = 2;
    for (int k = 6; k < 10; k++) begin
      vins[k] = N'($urandom_range(2047, 0));
      modes[k] = 0;
    end
    for (int k = 0; k < 10; k++) begin
      comp_mode = modes[k];
      exp_r = model_result(vins[k], modes[k]);
      run_conversion(vins[k], 1'b0, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL values_latency[%0d]: got %0d expected %0d", k, lat, LAT); end
      n_checks++; if (result !== exp_r) begin n_fail++; $display("FAIL values_result[%0d]: got %h expected %h", k, result, exp_r); end
      if (modes[k] == 0) begin
        n_checks++;
        if (trace_at(SC + 4 * BIT_CYC) !== model_trial(vins[k], 4)) begin
          n_fail++; $display("FAIL values_trial4[%0d]: got %h expected %h", k, trace_at(SC + 4 * BIT_CYC), model_trial(vins[k], 4));
        end
      end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL values_busy_after[%0d]: got %b expected 0", k, busy); end
      $display("test_values vin=%h mode=%0d result=%h", vins[k], modes[k], result);
    end
    comp_mode = 0;
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    logic [N-1:0] res_seen[$];
    int drops = 0;
    vin_code = N'(100);
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 3 * LAT && done_cyc.size() < 2; c++) begin
      if (busy !== 1'b1) drops++;
      if (done) begin
        done_cyc.push_back(c);
        res_seen.push_back(result);
        vin_code = N'(2000);
      end
      if (done_cyc.size() < 2) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    n_checks++; if (done_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc.size()); end
    if (done_cyc.size() == 2) begin
      n_checks++; if (done_cyc[0] !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", done_cyc[0], LAT); end
      n_checks++; if (done_cyc[1] - done_cyc[0] !== LAT) begin n_fail++; $display("FAIL b2b_period: got %0d expected %0d", done_cyc[1] - done_cyc[0], LAT); end
      n_checks++; if (res_seen[0] !== N'(100)) begin n_fail++; $display("FAIL b2b_result0: got %h expected %h", res_seen[0], N'(100)); end
      n_checks++; if (res_seen[1] !== N'(2000)) begin n_fail++; $display("FAIL b2b_result1: got %h expected %h", res_seen[1], N'(2000)); end
    end
    n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL b2b_busy_drops: got %0d expected 0", drops); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
    $display("test_back_to_back dones=%0d", done_cyc.size());
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    logic [N-1:0] v;
    v = N'($urandom_range(2047, 1));
    vin_code = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      start = (c == SC + 4);
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    n_checks++; if (result !== v) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", result, v); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_idle: got %b expected 0", busy); end
    $display("test_start_ignored vin=%h dones=%0d result=%h", v, dones, result);
  endtask

  task automatic test_async_reset();
    int lat;
    logic [N-1:0] v;
    run_conversion(N'(12'h555), 1'b0, lat);
    @(posedge clk); #1;
    vin_code = N'(12'h2AA);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (SC + 4 * BIT_CYC) @(posedge clk);
    #3;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (track !== 1'b0) begin n_fail++; $display("FAIL areset_track: got %b expected 0", track); end
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL areset_dac: got %h expected 000", dac_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b expected 0", done); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL areset_result: got %h expected 000", result); end
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    v = N'($urandom_range(2047, 0));
    run_conversion(v, 1'b0, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL areset_next_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (result !== v) begin n_fail++; $display("FAIL areset_next_result: got %h expected %h", result, v); end
    @(posedge clk); #1;
    $display("test_async_reset next vin=%h result=%h", v, result);
  endtask

`ifdef SAR_CTRL_COMP_SETTLE_EN
  task automatic test_settle();
    int lat;
    run_conversion(N'(1234), 1'b1, lat);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL settle_latency: got %0d expected 25", lat); end
    n_checks++; if (result !== N'(1234)) begin n_fail++; $display("FAIL settle_result: got %h expected %h", result, N'(1234)); end
    @(posedge clk); #1;
    $display("test_settle vin=%h result=%h latency=%0d", N'(1234), result, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
`ifdef SAR_CTRL_COMP_SETTLE_EN
    test_settle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
